// File: rtl/pci_target.sv
// PCI-style bus target: claims read/write bursts at myaddress into an 8 x 32-bit buffer.
// Latency: write data accepted from the first edge after the address; read data 2 edges after the address.
// Backpressure: irdy high inserts wait states; trdy is never deasserted once a data phase is open.
module pci_target (
    input  logic        clk,
    input  logic        reset_n,
    inout  wire  [31:0] bus,
    input  logic [3:0]  C_be,
    input  logic        frame,
    input  logic        irdy,
    inout  wire         trdy,
    inout  wire         devsel,
    input  logic [31:0] myaddress,
    output logic [4:0]  xfer_count
);

    localparam logic [3:0] CMD_RD = 4'b0110;
    localparam logic [3:0] CMD_WR = 4'b0111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TURN    = 2'd1,
        DATA    = 2'd2,
        BACKOFF = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        frame_q;     // frame as sampled on the previous edge, to find the address phase
    logic        is_wr_q;     // command latched at claim time
    logic [2:0]  idx_q;       // buffer index, wraps 7 -> 0
    logic [31:0] mem_q [8];

    logic        claim;
    logic        phase_done;
    logic        trdy_en;
    logic        trdy_val;
    logic        devsel_val;
    logic        bus_en;
    logic [31:0] rd_dat;

    // Next-state decode and bus-driver enables, all derived from the current state
    always_comb begin
        state_d    = state_q;
        claim      = 1'b0;
        phase_done = 1'b0;
        trdy_en    = 1'b0;
        trdy_val   = 1'b1;
        devsel_val = 1'b1;
        bus_en     = 1'b0;
        rd_dat     = mem_q[idx_q];
        case (state_q)
            IDLE: begin
                // Address phase is the first edge with frame low after it was high
                if (!frame && frame_q && (bus == myaddress) &&
                    ((C_be == CMD_RD) || (C_be == CMD_WR))) begin
                    claim   = 1'b1;
                    state_d = (C_be == CMD_WR) ? DATA : TURN;
                end
            end
            TURN: begin
                // One turnaround cycle so the initiator can release the AD lines
                trdy_en    = 1'b1;
                devsel_val = 1'b0;
                state_d    = DATA;
            end
            DATA: begin
                trdy_en    = 1'b1;
                trdy_val   = 1'b0;
                devsel_val = 1'b0;
                bus_en     = !is_wr_q;
                phase_done = !irdy;
                // frame high ends the burst: either after this last phase or abandoned without one
                if (frame) begin
                    state_d = BACKOFF;
                end
            end
            BACKOFF: begin
                // Drive the handshake lines high for one cycle before releasing them
                trdy_en = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign trdy   = trdy_en ? trdy_val   : 1'bz;
    assign devsel = trdy_en ? devsel_val : 1'bz;
    assign bus    = bus_en  ? rd_dat     : 32'bz;

    // State register and previous-frame sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            frame_q <= 1'b0;   // a burst already in flight when reset lifts is not claimed
        end else begin
            state_q <= state_d;
            frame_q <= frame;
        end
    end

    // Command latch, buffer index and saturating completed-phase counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_wr_q    <= 1'b0;
            idx_q      <= 3'd0;
            xfer_count <= 5'd0;
        end else if (claim) begin
            is_wr_q    <= (C_be == CMD_WR);
            idx_q      <= 3'd0;
            xfer_count <= 5'd0;
        end else if (phase_done) begin
            idx_q <= idx_q + 3'd1;
            if (xfer_count != 5'd31) begin
                xfer_count <= xfer_count + 5'd1;
            end
        end
    end

    // Buffer write: only lanes whose active-low byte enable is asserted are updated
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (phase_done && is_wr_q) begin
            for (int k = 0; k < 4; k++) begin
                if (!C_be[k]) begin
                    mem_q[idx_q][8*k +: 8] <= bus[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_pci_target.sv
// Directed and randomized bursts against a transaction-level model of the target buffer.
// Released lines are pulled high, so an undriven net reads as all ones.
// All inputs change on the falling edge; outputs are sampled on the falling edge before that.
module tb_pci_target;

    localparam logic [31:0] MY     = 32'hAAAA_AAAA;
    localparam logic [31:0] FLOAT  = 32'hFFFF_FFFF;
    localparam logic [3:0]  CMD_RD = 4'b0110;
    localparam logic [3:0]  CMD_WR = 4'b0111;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    tri1  [31:0] bus;
    tri1         trdy;
    tri1         devsel;
    logic [3:0]  c_be    = 4'hF;
    logic        frame   = 1'b1;
    logic        irdy    = 1'b1;
    logic [31:0] tb_bus  = 32'h0;
    logic        tb_oe   = 1'b0;
    logic [4:0]  xfer_count;

    int total = 0;
    int bad   = 0;

    // Reference model: buffer contents and the expected phase count of the last claimed burst
    logic [31:0] mdl_mem [8];
    int          mdl_xfer;
    logic [31:0] wd [40];
    logic [3:0]  wb [40];

    assign bus = tb_oe ? tb_bus : 32'bz;

    always #5 clk = ~clk;

    pci_target dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .C_be       (c_be),
        .frame      (frame),
        .irdy       (irdy),
        .trdy       (trdy),
        .devsel     (devsel),
        .myaddress  (MY),
        .xfer_count (xfer_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{~be[3]}}, {8{~be[2]}}, {8{~be[1]}}, {8{~be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic int sat31(input int n);
        return (n > 31) ? 31 : n;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mdl_mem[i] = 32'h0;
        mdl_xfer = 0;
    endtask

    // Write burst of n phases from wd/wb with wmin..wmax wait states before each phase
    task automatic wr_txn(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                          input int wmin, input int wmax);
        bit claim;
        int w;
        claim = (addr == MY) && (cmd == CMD_WR);
        frame = 1'b0; irdy = 1'b1; c_be = cmd; tb_bus = addr; tb_oe = 1'b1;
        @(negedge clk);
        for (int p = 0; p < n; p++) begin
            w = $urandom_range(wmax, wmin);
            for (int k = 0; k < w; k++) begin
                irdy = 1'b1; tb_bus = $urandom; c_be = 4'($urandom_range(15, 0));
                chk1("wr_wait_devsel", devsel, !claim);
                chk1("wr_wait_trdy", trdy, !claim);
                @(negedge clk);
            end
            chk1("wr_devsel", devsel, !claim);
            chk1("wr_trdy", trdy, !claim);
            irdy = 1'b0; tb_bus = wd[p]; c_be = wb[p]; frame = (p == n - 1);
            if (claim) mdl_mem[p % 8] = merge(mdl_mem[p % 8], wd[p], wb[p]);
            @(negedge clk);
        end
        chk1("wr_bo_trdy", trdy, 1'b1);
        chk1("wr_bo_devsel", devsel, 1'b1);
        frame = 1'b1; irdy = 1'b1; tb_oe = 1'b0; c_be = 4'hF;
        @(negedge clk);
        if (claim) mdl_xfer = sat31(n);
        chk1("wr_idle_trdy", trdy, 1'b1);
        chk1("wr_idle_devsel", devsel, 1'b1);
        chk("wr_idle_bus", bus, FLOAT);
        chk("wr_xfer", 32'(xfer_count), 32'(mdl_xfer));
    endtask

    // Read burst of n phases, checking every word and wait-state stability
    task automatic rd_txn(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                          input int wmin, input int wmax);
        bit claim;
        int w;
        logic [31:0] exp;
        claim = (addr == MY) && (cmd == CMD_RD);
        frame = 1'b0; irdy = 1'b1; c_be = cmd; tb_bus = addr; tb_oe = 1'b1;
        @(negedge clk);
        tb_oe = 1'b0; c_be = 4'h0;
        #1;
        chk1("rd_turn_trdy", trdy, 1'b1);
        chk1("rd_turn_devsel", devsel, !claim);
        chk("rd_turn_bus", bus, FLOAT);
        @(negedge clk);
        for (int p = 0; p < n; p++) begin
            exp = claim ? mdl_mem[p % 8] : FLOAT;
            w = $urandom_range(wmax, wmin);
            for (int k = 0; k < w; k++) begin
                irdy = 1'b1; frame = 1'b0;
                chk("rd_wait_bus", bus, exp);
                @(negedge clk);
            end
            chk("rd_bus", bus, exp);
            chk1("rd_trdy", trdy, !claim);
            chk1("rd_devsel", devsel, !claim);
            irdy = 1'b0; frame = (p == n - 1);
            @(negedge clk);
        end
        chk("rd_bo_bus", bus, FLOAT);
        chk1("rd_bo_trdy", trdy, 1'b1);
        chk1("rd_bo_devsel", devsel, 1'b1);
        frame = 1'b1; irdy = 1'b1; c_be = 4'hF;
        @(negedge clk);
        if (claim) mdl_xfer = sat31(n);
        chk1("rd_idle_trdy", trdy, 1'b1);
        chk("rd_idle_bus", bus, FLOAT);
        chk("rd_xfer", 32'(xfer_count), 32'(mdl_xfer));
    endtask

    initial begin
        int n;
        int kind;
        clear_model();

        // Reset state, observed before any clock edge
        #1;
        chk1("rst_trdy", trdy, 1'b1);
        chk1("rst_devsel", devsel, 1'b1);
        chk("rst_bus", bus, FLOAT);
        chk("rst_xfer", 32'(xfer_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Three-phase write then read-back
        wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333;
        for (int p = 0; p < 3; p++) wb[p] = 4'b0000;
        wr_txn(MY, CMD_WR, 3, 0, 0);
        rd_txn(MY, CMD_RD, 3, 0, 0);

        // Partial-lane write onto mem[0]
        wd[0] = 32'hDEAD_BEEF; wb[0] = 4'b1010;
        wr_txn(MY, CMD_WR, 1, 0, 0);
        rd_txn(MY, CMD_RD, 1, 0, 0);

        // Ten-phase write wraps the index
        for (int p = 0; p < 10; p++) begin
            wd[p] = 32'hC000_0000 + 32'(p + 1); wb[p] = 4'b0000;
        end
        wr_txn(MY, CMD_WR, 10, 0, 0);
        rd_txn(MY, CMD_RD, 8, 0, 0);

        // Foreign address and unsupported command are ignored
        for (int p = 0; p < 3; p++) begin wd[p] = $urandom; wb[p] = 4'b0000; end
        wr_txn(32'hBBBB_BBBB, CMD_WR, 3, 0, 0);
        wr_txn(MY, 4'b0010, 3, 0, 0);
        rd_txn(32'hBBBB_BBBB, CMD_RD, 2, 0, 0);

        // Read with three wait states per phase
        rd_txn(MY, CMD_RD, 3, 3, 3);

        // Initiator abandons before any phase
        frame = 1'b0; irdy = 1'b1; c_be = CMD_WR; tb_bus = MY; tb_oe = 1'b1;
        @(negedge clk);
        chk1("ab_devsel", devsel, 1'b0);
        frame = 1'b1; irdy = 1'b1; tb_bus = 32'h0BAD_0BAD; c_be = 4'h0;
        @(negedge clk);
        chk1("ab_bo_devsel", devsel, 1'b1);
        tb_oe = 1'b0; c_be = 4'hF;
        @(negedge clk);
        mdl_xfer = 0;
        chk("ab_xfer", 32'(xfer_count), 32'd0);
        rd_txn(MY, CMD_RD, 8, 0, 1);

        // Long burst saturates the phase counter
        for (int p = 0; p < 33; p++) begin wd[p] = $urandom; wb[p] = 4'($urandom_range(15, 0)); end
        wr_txn(MY, CMD_WR, 33, 0, 0);
        rd_txn(MY, CMD_RD, 8, 0, 0);

        // Randomized mix of claimed and ignored bursts
        for (int t = 0; t < 16; t++) begin
            n = $urandom_range(10, 1);
            kind = $urandom_range(6, 0);
            for (int p = 0; p < n; p++) begin
                wd[p] = $urandom; wb[p] = 4'($urandom_range(15, 0));
            end
            case (kind)
                0, 1, 2: wr_txn(MY, CMD_WR, n, 0, 2);
                3, 4:    rd_txn(MY, CMD_RD, n, 0, 2);
                5:       wr_txn(MY ^ (32'h1 << $urandom_range(31, 0)), CMD_WR, n, 0, 1);
                default: rd_txn(MY, 4'b0010, n, 0, 1);
            endcase
        end
        rd_txn(MY, CMD_RD, 8, 0, 0);

        // Reset pulsed during the second phase of a four-phase write
        for (int p = 0; p < 4; p++) begin wd[p] = $urandom; wb[p] = 4'b0000; end
        frame = 1'b0; irdy = 1'b1; c_be = CMD_WR; tb_bus = MY; tb_oe = 1'b1;
        @(negedge clk);
        irdy = 1'b0; tb_bus = wd[0]; c_be = wb[0];
        @(negedge clk);
        chk("mid_xfer", 32'(xfer_count), 32'd1);
        chk1("mid_trdy", trdy, 1'b0);
        tb_bus = wd[1]; c_be = wb[1];
        #2;
        reset_n = 1'b0;
        #1;
        chk1("arst_trdy", trdy, 1'b1);
        chk1("arst_devsel", devsel, 1'b1);
        chk("arst_xfer", 32'(xfer_count), 32'd0);
        clear_model();
        frame = 1'b1; irdy = 1'b1; tb_oe = 1'b0; c_be = 4'hF;
        #1;
        chk("arst_bus", bus, FLOAT);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_txn(MY, CMD_RD, 8, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
